// File: rtl/fifo_rr_pkg.sv
// Shared definitions for the round-robin FIFO drain scheduler and its arbiters.
package fifo_rr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Burst counter width; covers the largest legal BURST of 255.
    localparam int unsigned CNT_W = 8;

    // Channel-ID width needed to address ch channels (at least 1 bit).
    function automatic int unsigned cw_for_ch(input int unsigned ch);
        return (ch <= 1) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping mod N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW:0] cand;

    // Walk ptr, ptr+1, ... with an explicit wrap so non-power-of-2 N works.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = {1'b0, ptr_i} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found_o && req_i[cand[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of CH FWFT FIFOs into one registered valid/ready stream.
// Optional macro FIFO_RR_DRAIN_LAST_EN adds m_last (end-of-grant marker) at the
// cost of one extra cycle of pop-to-valid latency.
module fifo_rr_drain
    import fifo_rr_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned CH    = 4,
    parameter int unsigned CW    = 2,
    parameter int unsigned BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    ch_empty,
    input  logic [CH*DW-1:0] ch_dout,
    output logic [CH-1:0]    ch_rd_en,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    output logic [CW-1:0]    m_ch,
    input  logic             m_ready,
`ifdef FIFO_RR_DRAIN_LAST_EN
    output logic             m_last,
`endif
    output logic             busy
);

    // Parameter legality is enforced at elaboration.
    if (CH < 2 || CH > 16 || CW != cw_for_ch(CH)) begin : g_bad_ch
        $fatal(1, "fifo_rr_drain: illegal CH/CW combination");
    end
    if (BURST < 1 || BURST > 255) begin : g_bad_burst
        $fatal(1, "fifo_rr_drain: BURST out of range");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
    localparam logic [CW-1:0]    CH_MAX   = CW'(CH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     gnt_q, gnt_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              m_valid_q, m_valid_d;
    logic [DW-1:0]     m_data_q, m_data_d;
    logic [CW-1:0]     m_ch_q, m_ch_d;
    logic              busy_q;

    logic [CH-1:0]     rd_en_c;
    logic              can_pop_c;
    logic              out_free_c;
    logic              gnt_empty_c;
    logic              burst_end_c;
    logic [CW-1:0]     pick_idx;
    logic              pick_found;
    logic [DW-1:0]     dout_a [CH];

`ifdef FIFO_RR_DRAIN_LAST_EN
    logic              stg_v_q, stg_v_d;
    logic [DW-1:0]     stg_data_q, stg_data_d;
    logic [CW-1:0]     stg_ch_q, stg_ch_d;
    logic              stg_end_q, stg_end_d;
    logic              m_last_q, m_last_d;
    logic              move_c;
`endif

    // Unpack the flat head-word bus into one word per channel.
    for (genvar g = 0; g < CH; g++) begin : g_dout
        assign dout_a[g] = ch_dout[g*DW +: DW];
    end

    rr_pick #(
        .N  (CH),
        .IW (CW)
    ) u_pick (
        .req_i   (~ch_empty),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Next-state, pop strobe and output-register update.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_ch_d      = m_ch_q;
        rd_en_c     = '0;
        can_pop_c   = 1'b0;
        out_free_c  = !m_valid_q || m_ready;
        gnt_empty_c = ch_empty[gnt_q];
        burst_end_c = (cnt_q == LAST_CNT);
`ifdef FIFO_RR_DRAIN_LAST_EN
        stg_v_d     = stg_v_q;
        stg_data_d  = stg_data_q;
        stg_ch_d    = stg_ch_q;
        stg_end_d   = stg_end_q;
        m_last_d    = m_last_q;
        move_c      = stg_v_q && out_free_c;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
`ifdef FIFO_RR_DRAIN_LAST_EN
                can_pop_c = !gnt_empty_c && (!stg_v_q || out_free_c);
`else
                can_pop_c = !gnt_empty_c && out_free_c;
`endif
                rd_en_c[gnt_q] = can_pop_c;
                if (can_pop_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((can_pop_c && burst_end_c) || gnt_empty_c) begin
                    state_d = ST_IDLE;
                    ptr_d   = (gnt_q == CH_MAX) ? '0 : gnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef FIFO_RR_DRAIN_LAST_EN
        // Popped word waits one cycle in the stage so the channel's post-pop
        // empty flag can decide m_last.
        if (can_pop_c) begin
            stg_v_d    = 1'b1;
            stg_data_d = dout_a[gnt_q];
            stg_ch_d   = gnt_q;
            stg_end_d  = burst_end_c;
        end else if (move_c) begin
            stg_v_d = 1'b0;
        end
        if (move_c) begin
            m_valid_d = 1'b1;
            m_data_d  = stg_data_q;
            m_ch_d    = stg_ch_q;
            m_last_d  = stg_end_q || ch_empty[stg_ch_q];
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
`else
        if (can_pop_c) begin
            m_valid_d = 1'b1;
            m_data_d  = dout_a[gnt_q];
            m_ch_d    = gnt_q;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
`endif
    end

    // State and datapath registers; reset drops any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_ch_q     <= '0;
            busy_q     <= 1'b0;
`ifdef FIFO_RR_DRAIN_LAST_EN
            stg_v_q    <= 1'b0;
            stg_data_q <= '0;
            stg_ch_q   <= '0;
            stg_end_q  <= 1'b0;
            m_last_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_ch_q     <= m_ch_d;
            busy_q     <= (state_d == ST_GRANT);
`ifdef FIFO_RR_DRAIN_LAST_EN
            stg_v_q    <= stg_v_d;
            stg_data_q <= stg_data_d;
            stg_ch_q   <= stg_ch_d;
            stg_end_q  <= stg_end_d;
            m_last_q   <= m_last_d;
`endif
        end
    end

    assign ch_rd_en = rst ? '0 : rd_en_c;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_ch     = m_ch_q;
    assign busy     = busy_q;
`ifdef FIFO_RR_DRAIN_LAST_EN
    assign m_last   = m_last_q;
`endif

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: behavioural FWFT FIFOs feed the DUT and a
// monitor logs pops and accepted output words for per-test checks.
module tb_fifo_rr_drain;

    localparam int unsigned DW    = 8;
    localparam int unsigned CH    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned BURST = 4;
`ifdef FIFO_RR_DRAIN_LAST_EN
    localparam int STALL_POPS = 2;
`else
    localparam int STALL_POPS = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    ch_empty;
    logic [CH*DW-1:0] ch_dout;
    logic [CH-1:0]    ch_rd_en;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic [CW-1:0]    m_ch;
    logic             m_ready;
    logic             busy;
`ifdef FIFO_RR_DRAIN_LAST_EN
    logic             m_last;
`endif

    logic [7:0] mem    [CH][256];
    logic [7:0] wr_ptr [CH];
    logic [7:0] rd_ptr [CH] = '{default: 8'd0};

    int         cyc        = 0;
    int         pop_n      = 0;
    int         pop_cyc    [256];
    int         pops_ch    [CH] = '{default: 0};
    int         onehot_err = 0;
    int         log_n      = 0;
    logic [7:0] log_data   [256];
    logic [1:0] log_ch     [256];
    logic       log_last   [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_rr_drain #(
        .DW    (DW),
        .CH    (CH),
        .CW    (CW),
        .BURST (BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_empty (ch_empty),
        .ch_dout  (ch_dout),
        .ch_rd_en (ch_rd_en),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ch     (m_ch),
        .m_ready  (m_ready),
`ifdef FIFO_RR_DRAIN_LAST_EN
        .m_last   (m_last),
`endif
        .busy     (busy)
    );

    // FWFT read side of the behavioural FIFOs.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            ch_empty[i]         = (rd_ptr[i] == wr_ptr[i]);
            ch_dout[i*DW +: DW] = mem[i][rd_ptr[i]];
        end
    end

    // Pop handling plus pop/output logging.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < CH; i++) begin
            if (ch_rd_en[i]) begin
                rd_ptr[i]  <= rd_ptr[i] + 8'd1;
                pops_ch[i] <= pops_ch[i] + 1;
            end
        end
        if (ch_rd_en != '0) begin
            pop_cyc[pop_n] <= cyc;
            pop_n          <= pop_n + 1;
        end
        if ($countones(ch_rd_en) > 1) onehot_err <= onehot_err + 1;
        if (!rst && m_valid && m_ready) begin
            log_data[log_n] <= m_data;
            log_ch[log_n]   <= m_ch;
`ifdef FIFO_RR_DRAIN_LAST_EN
            log_last[log_n] <= m_last;
`else
            log_last[log_n] <= 1'b0;
`endif
            log_n <= log_n + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < CH; c++) wr_ptr[c] = rd_ptr[c];
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load(input int c, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) mem[c][wr_ptr[c] + 8'(k)] = base + 8'(k);
        wr_ptr[c] = wr_ptr[c] + 8'(n);
    endtask

    task automatic wait_words(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (log_n >= target) break;
            @(negedge clk);
        end
        n_cmp++;
        if (log_n < target) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d words, need %0d", name, log_n, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < CH; c++) wr_ptr[c] = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (m_data !== 8'h00 || m_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_out: got data=%h ch=%0d, need 00/0", m_data, m_ch);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ch_rd_en !== 4'b0000 || m_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle: cyc %0d got rd_en=%b valid=%b busy=%b, need 0/0/0",
                         i, ch_rd_en, m_valid, busy);
            end
        end
    endtask

    task automatic test_single_channel();
        int b, p, gap, exp_gap;
        do_reset();
        b = log_n;
        p = pop_n;
        load(0, 10, 8'h10);
        wait_words(b + 10, 100, "single");
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (log_ch[b+k] !== 2'd0 || log_data[b+k] !== 8'h10 + 8'(k)) begin
                n_bad++;
                $display("FAIL single_word%0d: got ch=%0d data=%h, need 0/%h",
                         k, log_ch[b+k], log_data[b+k], 8'h10 + 8'(k));
            end
        end
        for (int k = 1; k < 10; k++) begin
            gap     = pop_cyc[p+k] - pop_cyc[p+k-1];
            exp_gap = (k == 4 || k == 8) ? 2 : 1;
            n_cmp++;
            if (gap !== exp_gap) begin
                n_bad++;
                $display("FAIL single_gap%0d: got %0d, need %0d", k, gap, exp_gap);
            end
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got busy=%b valid=%b, need 0/0", busy, m_valid);
        end
    endtask

    task automatic test_two_channels();
        int b, grp, c, idx;
        logic [7:0] exp_d;
        do_reset();
        b = log_n;
        load(1, 8, 8'h40);
        load(3, 8, 8'h80);
        wait_words(b + 16, 200, "two_ch");
        for (int k = 0; k < 16; k++) begin
            grp   = k / 4;
            c     = (grp % 2 == 0) ? 1 : 3;
            idx   = (grp / 2) * 4 + (k % 4);
            exp_d = ((c == 1) ? 8'h40 : 8'h80) + 8'(idx);
            n_cmp++;
            if (log_ch[b+k] !== 2'(c) || log_data[b+k] !== exp_d) begin
                n_bad++;
                $display("FAIL two_ch_word%0d: got ch=%0d data=%h, need %0d/%h",
                         k, log_ch[b+k], log_data[b+k], c, exp_d);
            end
        end
    endtask

    task automatic test_backpressure();
        int b, p2;
        do_reset();
        m_ready = 1'b0;
        p2 = pops_ch[2];
        b  = log_n;
        load(2, 3, 8'hA0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) break;
        end
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_first_valid: got %b, need 1", m_valid);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== 8'hA0 || m_ch !== 2'd2 || ch_rd_en !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h ch=%0d rd_en=%b, need 1/a0/2/0000",
                         i, m_valid, m_data, m_ch, ch_rd_en);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pops_ch[2] - p2 !== STALL_POPS) begin
            n_bad++;
            $display("FAIL bp_pops: got %0d, need %0d", pops_ch[2] - p2, STALL_POPS);
        end
        m_ready = 1'b1;
        wait_words(b + 3, 50, "bp");
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (log_ch[b+k] !== 2'd2 || log_data[b+k] !== 8'hA0 + 8'(k)) begin
                n_bad++;
                $display("FAIL bp_word%0d: got ch=%0d data=%h, need 2/%h",
                         k, log_ch[b+k], log_data[b+k], 8'hA0 + 8'(k));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int b, p0;
        do_reset();
        b = log_n;
        load(1, 1, 8'h55);
        wait_words(b + 1, 30, "mid_pre");
        repeat (3) @(negedge clk);
        p0 = pops_ch[0];
        load(0, 10, 8'hC0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pops_ch[0] - p0 >= 2) break;
        end
        n_cmp++;
        if (pops_ch[0] - p0 !== 2) begin
            n_bad++;
            $display("FAIL mid_pops: got %0d, need 2", pops_ch[0] - p0);
        end
        rst = 1'b1;
        load(2, 4, 8'hE0);
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b0 || ch_rd_en !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst: got valid=%b rd_en=%b busy=%b, need 0/0000/0",
                     m_valid, ch_rd_en, busy);
        end
        rst = 1'b0;
        b = log_n;
        wait_words(b + 5, 60, "mid_post");
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (log_ch[b+k] !== 2'd0 || log_data[b+k] !== 8'hC2 + 8'(k)) begin
                n_bad++;
                $display("FAIL mid_word%0d: got ch=%0d data=%h, need 0/%h",
                         k, log_ch[b+k], log_data[b+k], 8'hC2 + 8'(k));
            end
        end
        n_cmp++;
        if (log_ch[b+4] !== 2'd2 || log_data[b+4] !== 8'hE0) begin
            n_bad++;
            $display("FAIL mid_next_grant: got ch=%0d data=%h, need 2/e0", log_ch[b+4], log_data[b+4]);
        end
    endtask

`ifdef FIFO_RR_DRAIN_LAST_EN
    task automatic test_last();
        int b;
        logic exp_l;
        do_reset();
        b = log_n;
        load(0, 6, 8'h30);
        wait_words(b + 6, 80, "last");
        for (int k = 0; k < 6; k++) begin
            exp_l = (k == 3 || k == 5);
            n_cmp++;
            if (log_last[b+k] !== exp_l || log_data[b+k] !== 8'h30 + 8'(k)) begin
                n_bad++;
                $display("FAIL last_word%0d: got last=%b data=%h, need %b/%h",
                         k, log_last[b+k], log_data[b+k], exp_l, 8'h30 + 8'(k));
            end
        end
    endtask
`endif

    task automatic test_one_hot();
        n_cmp++;
        if (onehot_err !== 0) begin
            n_bad++;
            $display("FAIL one_hot_rd_en: got %0d multi-pop cycles, need 0", onehot_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_two_channels();
        test_backpressure();
        test_reset_mid_burst();
`ifdef FIFO_RR_DRAIN_LAST_EN
        test_last();
`endif
        test_one_hot();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
